// File: rtl/fifo_rd_unpack.sv
// Pops wide FIFO words and streams them MSB slice first; first slice 2 cycles after a pop from IDLE.
// Holds the slice under m_ready backpressure; a one-word prefetch removes bubbles between words.
module fifo_rd_unpack #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter int RATIO     = 4,
   parameter int CNT_WIDTH = 2
) (
   input  logic                 rd_clk,
   input  logic                 rd_rst,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [IN_WIDTH-1:0]  fifo_rd_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [OUT_WIDTH-1:0] m_data,
   output logic                 m_last
);

   typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 1);

   state_t                state, state_nxt;
   logic [IN_WIDTH-1:0]   sh_reg;
   logic [IN_WIDTH-1:0]   pf_reg;
   logic [CNT_WIDTH-1:0]  cnt;
   logic                  pf_vld;
   logic                  pend;
   logic                  at_last;
   logic                  fire;
   logic                  fire_last;

   assign at_last   = (cnt == CNT_LAST);
   assign fire      = m_valid & m_ready;
   assign fire_last = fire & at_last;

   // Pops never look at m_ready, so a stalled consumer still gets its next word prefetched.
   assign fifo_rd_en = !rd_rst & !fifo_empty & !pend &
                       ((state == IDLE) | ((state == SEND) & !pf_vld));

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      m_valid   = 1'b0;
      m_data    = '0;
      m_last    = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_rd_en) state_nxt = WAIT;
         end
         WAIT: begin
            state_nxt = SEND;
         end
         SEND: begin
            m_valid = 1'b1;
            m_data  = sh_reg[IN_WIDTH-1 -: OUT_WIDTH];
            m_last  = at_last;
            // Word done with nothing buffered: a pop issued this same cycle still needs its WAIT.
            if (fire_last & !pf_vld & !pend) begin
               state_nxt = fifo_rd_en ? WAIT : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         sh_reg <= '0;
         pf_reg <= '0;
         cnt    <= '0;
         pf_vld <= 1'b0;
         pend   <= 1'b0;
      end else begin
         pend <= fifo_rd_en;
         case (state)
            WAIT: begin
               sh_reg <= fifo_rd_data;
               cnt    <= '0;
            end
            SEND: begin
               if (fire & !at_last) begin
                  sh_reg <= sh_reg << OUT_WIDTH;
                  cnt    <= cnt + CNT_WIDTH'(1);
               end else if (fire_last) begin
                  cnt <= '0;
                  if (pf_vld) begin
                     sh_reg <= pf_reg;
                     pf_vld <= 1'b0;
                  end else if (pend) begin
                     sh_reg <= fifo_rd_data;
                  end
               end
               // Data landing while the current word is still busy parks in the prefetch slot.
               if (pend & !fire_last) begin
                  pf_reg <= fifo_rd_data;
                  pf_vld <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
